pixel_fetch_ctrl: RTL and testbench

Upstream producer for the 25 MHz VGA pixel FIFO, running in the 100 MHz write domain. It walks a frame buffer in raster order (H_ACTIVE x V_ACTIVE pixels, one 24-bit RGB word per pixel) through a fixed-latency synchronous memory read port. Fetched pixels pass through a small skid buffer, then into the async FIFO write port, and the block never overruns the FIFO. Frame base address is sampled per frame, which allows double buffering.

---
 rtl/pixel_fetch_ctrl_pkg.sv | 17 +
 rtl/pixel_fetch_ctrl_skid_buf.sv | 51 +++++
 rtl/pixel_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_pixel_fetch_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the frame-buffer pixel fetch path.
// Counter widths are common with the VGA timing logic in the read domain.
package pixel_fetch_ctrl_pkg;

    localparam int DATA_W   = 24;
    localparam int ADDR_W   = 20;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int CNT_W    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pixel_fetch_ctrl_skid_buf.sv
// Circular skid buffer between the memory read port and the pixel FIFO.
// Head reads as zero while empty so fifo_din is clean when nothing is queued.
module pixel_skid_buf #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [CW-1:0]     o_count,
    output logic [DATA_W-1:0] o_head
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only; occupancy is tracked by the reset-cleared count.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/pixel_fetch_ctrl.sv
// Raster-order frame buffer reader feeding the async VGA pixel FIFO.
// Reads are credited against skid space so returning data always has a slot.
module pixel_fetch_ctrl #(
    parameter int H_ACTIVE = pixel_fetch_ctrl_pkg::H_ACTIVE,
    parameter int V_ACTIVE = pixel_fetch_ctrl_pkg::V_ACTIVE,
    parameter int DATA_W   = pixel_fetch_ctrl_pkg::DATA_W,
    parameter int ADDR_W   = pixel_fetch_ctrl_pkg::ADDR_W,
    parameter int RD_LAT   = 2,
    parameter int SKID_D   = RD_LAT + 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [ADDR_W-1:0]                    fb_base,
    output logic                                 mem_rd_en,
    output logic [ADDR_W-1:0]                    mem_addr,
    input  logic [DATA_W-1:0]                    mem_rd_data,
    input  logic                                 fifo_full,
    output logic                                 fifo_wr_en,
    output logic [DATA_W-1:0]                    fifo_din,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic [pixel_fetch_ctrl_pkg::CNT_W-1:0] pix_x,
    output logic [pixel_fetch_ctrl_pkg::CNT_W-1:0] pix_y
);

    import pixel_fetch_ctrl_pkg::*;

    localparam int CW = $clog2(SKID_D + 1);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_offset;
    logic [CNT_W-1:0]  r_x;
    logic [CNT_W-1:0]  r_y;
    logic [RD_LAT-1:0] r_vld;
    logic [CW-1:0]     r_inflight;

    logic [CW-1:0]     w_skid_cnt;
    logic [CW:0]       w_occ;
    logic [DATA_W-1:0] w_head;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_last_pix;
    logic              w_frame_end;

    assign w_occ       = {1'b0, w_skid_cnt} + {1'b0, r_inflight};
    assign w_issue     = (r_state == FETCH) && (w_occ < (CW+1)'(SKID_D));
    assign w_push      = r_vld[RD_LAT-1];
    assign w_pop       = (w_skid_cnt != '0) && !fifo_full;
    assign w_last_pix  = (r_x == X_LAST) && (r_y == Y_LAST);
    // Nothing in flight and one word left: this pop is the frame's last write.
    assign w_frame_end = (r_state == DRAIN) && (r_inflight == '0) &&
                         (w_skid_cnt == CW'(1)) && w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_offset   <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_vld      <= '0;
            r_inflight <= '0;
        end else begin
            r_vld <= RD_LAT'({r_vld, w_issue});
            case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_base   <= fb_base;
                        r_offset <= '0;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_state  <= FETCH;
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_offset <= r_offset + ADDR_W'(1);
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= (r_y == Y_LAST) ? '0 : r_y + CNT_W'(1);
                        end else begin
                            r_x <= r_x + CNT_W'(1);
                        end
                        if (w_last_pix) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_frame_end) begin
                        if (enable) begin
                            r_base   <= fb_base;
                            r_offset <= '0;
                            r_x      <= '0;
                            r_y      <= '0;
                            r_state  <= FETCH;
                        end else begin
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    pixel_skid_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (mem_rd_data),
        .i_pop   (w_pop),
        .o_count (w_skid_cnt),
        .o_head  (w_head)
    );

    assign mem_rd_en  = w_issue;
    assign mem_addr   = r_base + r_offset;
    assign fifo_wr_en = w_pop;
    assign fifo_din   = w_head;
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_end;
    assign pix_x      = r_x;
    assign pix_y      = r_y;

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Scoreboard bench for pixel_fetch_ctrl on an 8x4 frame with a 2-cycle memory.
module tb_pixel_fetch_ctrl;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int DW    = 24;
    localparam int AW    = 20;
    localparam int LAT   = 2;
    localparam int SD    = LAT + 2;
    localparam int FRAME = H * V;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [AW-1:0] fb_base;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          busy;
    logic          frame_done;
    logic [9:0]    pix_x;
    logic [9:0]    pix_y;

    pixel_fetch_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .RD_LAT   (LAT),
        .SKID_D   (SD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .fb_base     (fb_base),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .busy        (busy),
        .frame_done  (frame_done),
        .pix_x       (pix_x),
        .pix_y       (pix_y)
    );

    always #5 clk = ~clk;

    // Memory returns its own address, two cycles after the strobe.
    logic [AW-1:0] m_a1 = '0;
    logic [AW-1:0] m_a2 = '0;
    always @(posedge clk) begin
        m_a1 <= mem_addr;
        m_a2 <= m_a1;
    end
    assign mem_rd_data = DW'(m_a2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    bit            mon_en = 1'b0;
    logic [DW-1:0] sb_q[$];
    logic [AW-1:0] next_base = '0;
    logic [AW-1:0] cur_base  = '0;
    logic [AW-1:0] frame_first_addr = '0;
    int rd_off = 0, rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
    int first_rd_cyc = 0, last_rd_cyc = 0, first_wr_cyc = 0;

    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (mon_en) begin
            if (mem_rd_en === 1'b1) begin
                if (rd_off == 0) begin
                    cur_base = next_base;
                    frame_first_addr = mem_addr;
                    first_rd_cyc = cyc;
                end
                ea = cur_base + AW'(rd_off);
                checks++;
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL rd_addr: got %h want %h", mem_addr, ea);
                end
                checks++;
                if (pix_x !== 10'(rd_off % H) || pix_y !== 10'(rd_off / H)) begin
                    errors++;
                    $display("FAIL pix_xy: got %0d,%0d want %0d,%0d", pix_x, pix_y, rd_off % H, rd_off / H);
                end
                sb_q.push_back(DW'(ea));
                checks++;
                if (sb_q.size() > SD) begin
                    errors++;
                    $display("FAIL credit: outstanding %0d want <= %0d", sb_q.size(), SD);
                end
                last_rd_cyc = cyc;
                rd_off = (rd_off == FRAME - 1) ? 0 : rd_off + 1;
                rd_cnt++;
            end
            if (fifo_wr_en === 1'b1) begin
                checks++;
                if (fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_while_full: fifo_wr_en=1 with fifo_full=%b want no write", fifo_full);
                end
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra: got write %h want none outstanding", fifo_din);
                end else begin
                    ed = sb_q.pop_front();
                    if (fifo_din !== ed) begin
                        errors++;
                        $display("FAIL wr_data: got %h want %h", fifo_din, ed);
                    end
                end
                if (wr_cnt % FRAME == 0) first_wr_cyc = cyc;
                wr_cnt++;
                checks++;
                if (frame_done !== (wr_cnt % FRAME == 0)) begin
                    errors++;
                    $display("FAIL frame_done: got %b want %b at write %0d", frame_done, (wr_cnt % FRAME == 0), wr_cnt);
                end
                if (frame_done === 1'b1) done_cnt++;
            end else if (frame_done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL done_no_wr: frame_done=%b without write want 0", frame_done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb_q.delete();
        rd_off   = 0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (mem_rd_en !== 1'b0)  begin errors++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
        checks++; if (mem_addr !== '0)     begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", fifo_wr_en); end
        checks++; if (fifo_din !== '0)     begin errors++; $display("FAIL rst_din: got %h want 0", fifo_din); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", frame_done); end
        checks++; if (pix_x !== '0 || pix_y !== '0) begin errors++; $display("FAIL rst_pix: got %0d,%0d want 0,0", pix_x, pix_y); end
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
    endtask

    task automatic test_basic_frame();
        bit got;
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(200, got);
        tick();
        checks++; if (!got) begin errors++; $display("FAIL basic_done: got timeout want frame_done"); end
        checks++; if (wr_cnt !== FRAME || done_cnt !== 1) begin errors++; $display("FAIL basic_count: got %0d writes %0d dones want %0d 1", wr_cnt, done_cnt, FRAME); end
        checks++; if (last_rd_cyc - first_rd_cyc !== FRAME - 1) begin errors++; $display("FAIL basic_rate: got span %0d want %0d", last_rd_cyc - first_rd_cyc, FRAME - 1); end
        checks++; if (first_wr_cyc - first_rd_cyc < LAT + 1) begin errors++; $display("FAIL basic_latency: got %0d want >= %0d", first_wr_cyc - first_rd_cyc, LAT + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_fifo_full_stall();
        bit got;
        int wr_at, rd_mid;
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (8) tick();
        fifo_full = 1'b1;
        wr_at = wr_cnt;
        repeat (6) tick();
        rd_mid = rd_cnt;
        repeat (14) tick();
        checks++; if (rd_cnt !== rd_mid) begin errors++; $display("FAIL stall_reads: got %0d reads want %0d", rd_cnt, rd_mid); end
        checks++; if (wr_cnt !== wr_at) begin errors++; $display("FAIL stall_writes: got %0d writes want %0d", wr_cnt, wr_at); end
        checks++; if (sb_q.size() !== SD) begin errors++; $display("FAIL stall_credit: got %0d outstanding want %0d", sb_q.size(), SD); end
        fifo_full = 1'b0;
        wait_done(200, got);
        tick();
        checks++; if (!got || wr_cnt !== FRAME) begin errors++; $display("FAIL stall_frame: got done=%b writes=%0d want 1 %0d", got, wr_cnt, FRAME); end
    endtask

    task automatic test_base_switch();
        bit got;
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        repeat (10) tick();
        fb_base = 20'h400; next_base = 20'h400;
        wait_done(200, got);
        checks++; if (!got) begin errors++; $display("FAIL switch_done1: got timeout want frame_done"); end
        tick();
        enable = 1'b0;
        wait_done(200, got);
        tick();
        checks++; if (!got || wr_cnt !== 2 * FRAME || done_cnt !== 2) begin errors++; $display("FAIL switch_count: got %0d writes %0d dones want %0d 2", wr_cnt, done_cnt, 2 * FRAME); end
        checks++; if (frame_first_addr !== 20'h400) begin errors++; $display("FAIL switch_base: got %h want 400", frame_first_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL switch_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_enable_drop();
        bit got, stray;
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        tick();
        for (int i = 0; i < 100 && rd_cnt < 10; i++) tick();
        enable = 1'b0;
        wait_done(200, got);
        tick();
        checks++; if (!got || wr_cnt !== FRAME || done_cnt !== 1) begin errors++; $display("FAIL drop_frame: got done=%b writes=%0d want 1 %0d", got, wr_cnt, FRAME); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: got busy %b want 0", busy); end
        stray = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_en !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL drop_reads: got mem_rd_en after idle want none"); end
    endtask

    task automatic test_reset_mid();
        bit got, stray;
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        tick();
        enable = 1'b0;
        fifo_full = 1'b1;
        repeat (5) tick();
        rst = 1'b1; fifo_full = 1'b0; mon_en = 1'b0;
        tick();
        checks++; if (mem_rd_en !== 1'b0 || fifo_wr_en !== 1'b0) begin errors++; $display("FAIL mid_rst_strobes: got rd=%b wr=%b want 0 0", mem_rd_en, fifo_wr_en); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_status: got busy=%b done=%b want 0 0", busy, frame_done); end
        checks++; if (mem_addr !== '0 || fifo_din !== '0 || pix_x !== '0 || pix_y !== '0) begin errors++; $display("FAIL mid_rst_regs: got addr=%h din=%h x=%0d y=%0d want zeros", mem_addr, fifo_din, pix_x, pix_y); end
        rst = 1'b0;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (fifo_wr_en !== 1'b0 || mem_rd_en !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin errors++; $display("FAIL mid_rst_stale: got strobe from stale data want none"); end
        tick();
        clear_model();
        mon_en = 1'b1;
        next_base = 20'h200; fb_base = 20'h200; enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_done(200, got);
        tick();
        checks++; if (!got || wr_cnt !== FRAME) begin errors++; $display("FAIL mid_rst_frame: got done=%b writes=%0d want 1 %0d", got, wr_cnt, FRAME); end
        checks++; if (frame_first_addr !== 20'h200) begin errors++; $display("FAIL mid_rst_base: got %h want 200", frame_first_addr); end
    endtask

    task automatic test_full_toggle();
        clear_model();
        next_base = 20'h100; fb_base = 20'h100; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            fifo_full = ~fifo_full;
            tick();
        end
        fifo_full = 1'b0;
        tick();
        checks++; if (done_cnt !== 1 || wr_cnt !== FRAME) begin errors++; $display("FAIL toggle_frame: got %0d dones %0d writes want 1 %0d", done_cnt, wr_cnt, FRAME); end
        checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL toggle_leftover: got %0d outstanding want 0", sb_q.size()); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0; fb_base = '0;
        test_reset();
        test_basic_frame();
        test_fifo_full_stall();
        test_base_switch();
        test_enable_drop();
        test_reset_mid();
        test_full_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
